// File: rtl/pool2x2_relu_if.sv
// rtl/pool2x2_relu_if.sv - pixel stream bundle (data + qualifier, no backpressure)
interface pool2x2_relu_if #(
   parameter int DATA_W = 8
);
   logic signed [DATA_W-1:0] tdata;
   logic                     tvalid;

   modport master (output tdata, output tvalid);
   modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/pool2x2_relu.sv
// rtl/pool2x2_relu.sv - streaming 2x2/stride-2 max pool over the PE result stream
// Optional ReLU after pooling is enabled by defining POOL_RELU_EN.
module pool2x2_relu #(
   parameter int DATA_W    = 8,
   parameter int MAX_WIDTH = 64,
   parameter int DIM_W     = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start_i,
   input  logic [DIM_W-1:0]  cfg_width_i,
   input  logic [DIM_W-1:0]  cfg_height_i,
   pool2x2_relu_if.slave     s_px,
   pool2x2_relu_if.master    m_px,
   output logic              frame_done_o,
   output logic              cfg_err_o,
   output logic              busy_o
);
   localparam int BUF_D  = MAX_WIDTH / 2;
   localparam int BUF_AW = $clog2(BUF_D);
   localparam logic [DIM_W-1:0] MAX_W_C = DIM_W'(MAX_WIDTH);
   localparam logic [DIM_W-1:0] TWO_C   = DIM_W'(2);
   localparam logic [DIM_W-1:0] ONE_C   = DIM_W'(1);

   typedef enum logic [1:0] {IDLE, RUN_TOP, RUN_BOT} state_e;

   state_e                    state_q, state_d;
   logic [DIM_W-1:0]          col_q, col_d, row_q, row_d;
   logic [DIM_W-1:0]          width_q, width_d, height_q, height_d;
   logic signed [DATA_W-1:0]  h_reg_q, h_reg_d;
   logic signed [DATA_W-1:0]  out_data_q, out_data_d;
   logic                      out_valid_q, out_valid_d;
   logic                      frame_done_q, frame_done_d;
   logic                      cfg_err_q, cfg_err_d;
   logic signed [DATA_W-1:0]  line_q [BUF_D];

   logic                      cfg_ok, running, accept, last_col, last_row, odd_col;
   logic [BUF_AW-1:0]         pair_idx;
   logic signed [DATA_W-1:0]  pair_max, win_max;

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign cfg_ok   = (cfg_width_i >= TWO_C) && (cfg_width_i <= MAX_W_C) && (cfg_height_i >= TWO_C);
   assign running  = (state_q != IDLE);
   // A frame_start always wins: the coincident pixel belongs to neither frame.
   assign accept   = running && s_px.tvalid && !frame_start_i;
   assign last_col = (col_q == width_q - ONE_C);
   assign last_row = (row_q == height_q - ONE_C);
   assign odd_col  = col_q[0];
   assign pair_idx = col_q[BUF_AW:1];
   assign pair_max = smax(h_reg_q, s_px.tdata);
   assign win_max  = smax(pair_max, line_q[pair_idx]);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (frame_start_i) begin
         state_d = cfg_ok ? RUN_TOP : IDLE;
      end else if (accept && last_col) begin
         if (last_row) begin
            state_d = IDLE;
         end else begin
            state_d = (state_q == RUN_TOP) ? RUN_BOT : RUN_TOP;
         end
      end
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      width_d      = width_q;
      height_d     = height_q;
      h_reg_d      = h_reg_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;
      if (frame_start_i) begin
         col_d = '0;
         row_d = '0;
         if (cfg_ok) begin
            width_d  = cfg_width_i;
            height_d = cfg_height_i;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else if (accept) begin
         if (!odd_col) begin
            h_reg_d = s_px.tdata;
         end else if (state_q == RUN_BOT) begin
            out_valid_d = 1'b1;
`ifdef POOL_RELU_EN
            out_data_d  = (win_max[DATA_W-1] || (win_max == '0)) ? '0 : win_max;
`else
            out_data_d  = win_max;
`endif
         end
         if (last_col) begin
            col_d = '0;
            row_d = row_q + ONE_C;
            if (last_row) begin
               row_d        = '0;
               frame_done_d = 1'b1;
            end
         end else begin
            col_d = col_q + ONE_C;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         col_q        <= '0;
         row_q        <= '0;
         width_q      <= '0;
         height_q     <= '0;
         h_reg_q      <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         width_q      <= width_d;
         height_q     <= height_d;
         h_reg_q      <= h_reg_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   // Not reset: every entry is written in RUN_TOP before RUN_BOT reads it.
   always_ff @(posedge clk) begin
      if (accept && odd_col && (state_q == RUN_TOP)) begin
         line_q[pair_idx] <= pair_max;
      end
   end

   always_comb begin
      busy_o = running || frame_done_q;
   end

   assign m_px.tdata   = out_data_q;
   assign m_px.tvalid  = out_valid_q;
   assign frame_done_o = frame_done_q;
   assign cfg_err_o    = cfg_err_q;
endmodule

// File: tb/tb_pool2x2_relu.sv
// tb/tb_pool2x2_relu.sv - directed-vector bench for pool2x2_relu
module tb_pool2x2_relu;
   logic       clk = 1'b0;
   logic       reset;
   logic       frame_start;
   logic [6:0] cfg_width, cfg_height;
   logic       frame_done, cfg_err, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int out_q[$];
   int exp_q[$];
   int done_cnt = 0;

   int gaps[15] = '{1, 2, 3, 1, 3, 2, 1, 1, 2, 3, 2, 1, 3, 1, 2};
   int pix5[15] = '{1, -2, 3, 4, 50, 7, 0, -9, 2, 60, 11, 12, 13, 14, 15};
   int mix6[12] = '{-128, 127, 10, -1, -128, -3, -1, -128, 3, 4, -7, -100};
   int abt4[16] = '{2, 9, 4, 1, 3, 3, 8, 0, -1, -2, -3, -4, -5, -6, -7, 20};

   always #5 clk = ~clk;

   pool2x2_relu_if #(.DATA_W(8)) s_px ();
   pool2x2_relu_if #(.DATA_W(8)) m_px ();

   pool2x2_relu #(.DATA_W(8), .MAX_WIDTH(64), .DIM_W(7)) dut (
      .clk           (clk),
      .reset         (reset),
      .frame_start_i (frame_start),
      .cfg_width_i   (cfg_width),
      .cfg_height_i  (cfg_height),
      .s_px          (s_px),
      .m_px          (m_px),
      .frame_done_o  (frame_done),
      .cfg_err_o     (cfg_err),
      .busy_o        (busy)
   );

   always @(negedge clk) begin
      if (m_px.tvalid) out_q.push_back(int'(m_px.tdata));
      if (frame_done) done_cnt++;
   end

   function automatic int relu(input int v);
`ifdef POOL_RELU_EN
      return (v > 0) ? v : 0;
`else
      return v;
`endif
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      check({tag, "_count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_%0d", tag, i), (i < out_q.size()) ? out_q[i] : -999, exp_q[i]);
   endtask

   task automatic start(input int w, input int h);
      frame_start = 1'b1;
      cfg_width   = 7'(w);
      cfg_height  = 7'(h);
      s_px.tvalid = 1'b0;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic px(input int v);
      s_px.tvalid = 1'b1;
      s_px.tdata  = 8'(v);
      @(negedge clk);
      s_px.tvalid = 1'b0;
      s_px.tdata  = 8'sd127;
   endtask

   task automatic idle(input int n);
      s_px.tvalid = 1'b0;
      frame_start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset       = 1'b0;
      frame_start = 1'b0;
      cfg_width   = '0;
      cfg_height  = '0;
      s_px.tvalid = 1'b0;
      s_px.tdata  = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", int'(m_px.tvalid), 0);
      check("rst_out_data", int'(m_px.tdata), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      reset = 1'b1;
      idle(1);

      // 4x4 ramp, continuous pixels
      out_q.delete(); done_cnt = 0;
      start(4, 4);
      check("sq4_busy_start", int'(busy), 1);
      for (int v = 1; v <= 16; v++) px(v);
      check("sq4_done_pulse", int'(frame_done), 1);
      check("sq4_last_valid", int'(m_px.tvalid), 1);
      check("sq4_last_data", int'(m_px.tdata), 16);
      check("sq4_busy_done", int'(busy), 1);
      idle(1);
      check("sq4_busy_after", int'(busy), 0);
      check("sq4_done_after", int'(frame_done), 0);
      check("sq4_data_hold", int'(m_px.tdata), 16);
      idle(1);
      exp_q = '{6, 8, 14, 16};
      check_outs("sq4");
      check("sq4_done_cnt", done_cnt, 1);

      // negatives and extremes
      out_q.delete();
      start(4, 2);
      repeat (8) px(-5);
      idle(2);
      exp_q = '{relu(-5), relu(-5)};
      check_outs("neg");
      out_q.delete();
      start(6, 2);
      for (int i = 0; i < 12; i++) px(mix6[i]);
      idle(2);
      exp_q = '{127, 10, relu(-3)};
      check_outs("mix");

      // 5x3 with gaps; garbage data during gaps
      out_q.delete(); done_cnt = 0;
      start(5, 3);
      for (int i = 0; i < 15; i++) begin
         idle(gaps[i]);
         s_px.tdata = 8'sd127;
         px(pix5[i]);
         if (i == 13) check("odd_no_early_done", int'(frame_done), 0);
      end
      check("odd_done_pulse", int'(frame_done), 1);
      check("odd_no_final_valid", int'(m_px.tvalid), 0);
      idle(2);
      exp_q = '{7, 4};
      check_outs("odd");
      check("odd_done_cnt", done_cnt, 1);

      // configuration rejects
      out_q.delete();
      start(1, 4);
      check("err_w1", int'(cfg_err), 1);
      check("err_w1_busy", int'(busy), 0);
      start(66, 4);
      check("err_w66", int'(cfg_err), 1);
      check("err_w66_busy", int'(busy), 0);
      start(4, 1);
      check("err_h1", int'(cfg_err), 1);
      check("err_h1_busy", int'(busy), 0);
      idle(1);
      check("err_pulse_end", int'(cfg_err), 0);
      for (int v = 1; v <= 8; v++) px(v);
      idle(2);
      check("err_idle_outs", out_q.size(), 0);
      check("err_idle_busy", int'(busy), 0);
      start(64, 2);
      check("w64_accept_busy", int'(busy), 1);
      check("w64_accept_err", int'(cfg_err), 0);

      // abort: frame_start coincides with the 6th pixel
      out_q.delete(); done_cnt = 0;
      start(4, 4);
      for (int v = 1; v <= 5; v++) px(v);
      frame_start = 1'b1;
      cfg_width   = 7'd4;
      cfg_height  = 7'd4;
      s_px.tvalid = 1'b1;
      s_px.tdata  = 8'sd99;
      @(negedge clk);
      frame_start = 1'b0;
      s_px.tvalid = 1'b0;
      for (int i = 0; i < 16; i++) px(abt4[i]);
      idle(2);
      exp_q = '{9, 8, relu(-1), 20};
      check_outs("abort");
      check("abort_done_cnt", done_cnt, 1);

      // reset in RUN_BOT
      start(4, 4);
      for (int v = 1; v <= 5; v++) px(v);
      reset       = 1'b0;
      s_px.tvalid = 1'b1;
      s_px.tdata  = 8'sd6;
      @(negedge clk);
      s_px.tvalid = 1'b0;
      check("mrst_out_valid", int'(m_px.tvalid), 0);
      check("mrst_out_data", int'(m_px.tdata), 0);
      check("mrst_busy", int'(busy), 0);
      check("mrst_frame_done", int'(frame_done), 0);
      reset = 1'b1;
      idle(1);
      out_q.delete(); done_cnt = 0;
      px(7);
      idle(1);
      check("mrst_idle_busy", int'(busy), 0);
      start(4, 4);
      for (int v = 1; v <= 16; v++) px(v);
      idle(2);
      exp_q = '{6, 8, 14, 16};
      check_outs("post_rst");
      check("post_rst_done_cnt", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pool2x2_relu.md
# pool2x2_relu

Streaming 2x2 max-pooling stage with optional ReLU, stride 2, placed directly downstream of the PE array lane. It consumes the PE's 8-bit signed result stream (`out` / `out_en`) in raster order and emits one pooled 8-bit value per 2x2 window. A half-row line buffer holds top-row pair maxima until the matching bottom-row pair arrives.

## Interface
Parameters:
- DATA_W, 8, pixel width (signed, two's complement).
- MAX_WIDTH, 64, maximum feature-map width in pixels (even); line buffer depth MAX_WIDTH/2.
- DIM_W, 7, width of cfg_width / cfg_height.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- frame_start  in  1  pulse; latches cfg_width/cfg_height, starts a frame.
- cfg_width  in  DIM_W  feature-map width in pixels.
- cfg_height  in  DIM_W  feature-map height in pixels.
- in_data  in  DATA_W  signed pixel from PE `out`.
- in_valid  in  1  pixel qualifier from PE `out_en`.
- out_data  out  DATA_W  signed pooled pixel, registered.
- out_valid  out  1  one-cycle pulse per pooled pixel.
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted.
- cfg_err  out  1  one-cycle pulse on rejected configuration.
- busy  out  1  high while in RUN_TOP / RUN_BOT.

## Operation
- States: IDLE, RUN_TOP (even row), RUN_BOT (odd row).
- IDLE: in_valid ignored. frame_start with 2 <= cfg_width <= MAX_WIDTH and cfg_height >= 2 -> latch dims, clear col/row counters, go RUN_TOP. Otherwise pulse cfg_err, stay IDLE.
- Pixel accepted when in_valid=1 in RUN_TOP/RUN_BOT; in_valid may have arbitrary gaps; no backpressure.
- Even column: store in_data in h_reg.
- Odd column, RUN_TOP: buf[col>>1] <= max(h_reg, in_data).
- Odd column, RUN_BOT: result = max(h_reg, in_data, buf[col>>1]) -> out_data, out_valid.
- All comparisons signed, full DATA_W, no width growth.
- Odd cfg_width: last column accepted but never pooled. Odd cfg_height: last row accepted in RUN_TOP, no outputs.
- End of row (col == width-1): col <= 0, row++, toggle RUN_TOP/RUN_BOT. Last pixel of frame (row == height-1, col == width-1): go IDLE, pulse frame_done.
- frame_start while running: abort current frame, revalidate/relatch config, restart at row 0 col 0; an in_valid in the same cycle is dropped. No output for the aborted window.
- Reset (any time, including mid-frame): state IDLE, counters 0, h_reg 0, out_data 0, out_valid 0, frame_done 0, cfg_err 0, busy 0. Line buffer contents are not reset (always written in RUN_TOP before being read).

## Timing
- out_valid/out_data: cycle N+1 for bottom-right pixel accepted at cycle N. out_data holds last value between pulses.
- frame_done: cycle N+1 after last pixel accepted at N; coincides with final out_valid when both dims are even.
- cfg_err: cycle after the rejected frame_start.
- busy: high from cycle after accepted frame_start through the cycle frame_done is asserted inclusive (drops the following cycle).
- Back-to-back pixels at one per cycle sustained indefinitely; next frame_start accepted the cycle after frame_done.

## Configuration
- Macro `POOL_RELU_EN`.
- Defined: out_data = result if result > 0, else 0 (ReLU after pooling).
- Undefined: out_data = signed max unchanged; negative values pass through.

## Test plan
- 4x4 frame, rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, continuous in_valid -> out_valid pulses with 6, 8, 14, 16; frame_done with last; busy low afterward.
- 4x2 frame all -5 -> outputs 0, 0 with POOL_RELU_EN; -5, -5 without. Include -128 and 127 in a window -> 127.
- 5x3 frame with random 1-3 cycle gaps in in_valid -> exactly 2 outputs (col pairs 0-1, 2-3 of rows 0-1), correct maxima, frame_done after 15th pixel.
- frame_start with cfg_width=1, then cfg_width=MAX_WIDTH+2, then cfg_height=1 -> cfg_err pulse each time, no state change, in_valid ignored.
- 4x4 frame aborted by frame_start after 6 pixels (same cycle as in_valid) -> that pixel dropped, no output from aborted frame, new 4x4 frame produces correct 4 outputs.
- reset low mid-RUN_BOT -> next cycle all outputs 0, IDLE; subsequent full frame correct.
